// File: rtl/seg7_msg_scroller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared types and constants for the seven-segment message
//                scroller. It holds the character codes, the active-low
//                segment patterns (bit 0 = a ... bit 6 = g) and the FSM
//                state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  localparam int CHAR_W = 5;
  localparam int SEG_W  = 7;

  // Display mode derived from the stored length and scroll_en.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_STATIC = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  // Character codes beyond the hex digits 0x00..0x0F.
  localparam logic [CHAR_W-1:0] GLYPH_H     = 5'h10;
  localparam logic [CHAR_W-1:0] GLYPH_L     = 5'h11;
  localparam logic [CHAR_W-1:0] GLYPH_P     = 5'h12;
  localparam logic [CHAR_W-1:0] GLYPH_U     = 5'h13;
  localparam logic [CHAR_W-1:0] GLYPH_DASH  = 5'h14;
  localparam logic [CHAR_W-1:0] GLYPH_BLANK = 5'h1F;

  // Active-low segment patterns, packed as {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_H     = 7'h09;
  localparam logic [SEG_W-1:0] SEG_L     = 7'h47;
  localparam logic [SEG_W-1:0] SEG_P     = 7'h0C;
  localparam logic [SEG_W-1:0] SEG_U     = 7'h41;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

endpackage
`default_nettype wire

// File: rtl/seg7_msg_scroller_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_msg_scroller_if
//  Description : Character write channel, display controls and segment
//                outputs of the message scroller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_msg_scroller_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DEPTH      = 16
);
  import seg7_pkg::*;

  logic                         wr_valid;
  logic [CHAR_W-1:0]            wr_char;
  logic                         wr_ready;
  logic                         clear;
  logic                         scroll_en;
  logic                         dir;
  logic [$clog2(DEPTH+1)-1:0]   msg_len;
  logic [SEG_W*NUM_DIGITS-1:0]  hex;

  // Character source / controller side.
  modport master (
    output wr_valid, wr_char, clear, scroll_en, dir,
    input  wr_ready, msg_len, hex
  );

  // Scroller side.
  modport slave (
    input  wr_valid, wr_char, clear, scroll_en, dir,
    output wr_ready, msg_len, hex
  );

endinterface
`default_nettype wire

// File: rtl/seg7_msg_scroller_glyph.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_glyph
//  Description : Combinational character code to active-low segment decoder.
//                Undefined codes and 0x1F decode to blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph
  import seg7_pkg::*;
(
  input  wire logic [CHAR_W-1:0] code_i,
  output logic      [SEG_W-1:0]  seg_o
);

  // Glyph lookup; anything not listed falls through to blank.
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      5'h00:      seg_o = SEG_0;
      5'h01:      seg_o = SEG_1;
      5'h02:      seg_o = SEG_2;
      5'h03:      seg_o = SEG_3;
      5'h04:      seg_o = SEG_4;
      5'h05:      seg_o = SEG_5;
      5'h06:      seg_o = SEG_6;
      5'h07:      seg_o = SEG_7;
      5'h08:      seg_o = SEG_8;
      5'h09:      seg_o = SEG_9;
      5'h0A:      seg_o = SEG_A;
      5'h0B:      seg_o = SEG_B;
      5'h0C:      seg_o = SEG_C;
      5'h0D:      seg_o = SEG_D;
      5'h0E:      seg_o = SEG_E;
      5'h0F:      seg_o = SEG_F;
      GLYPH_H:    seg_o = SEG_H;
      GLYPH_L:    seg_o = SEG_L;
      GLYPH_P:    seg_o = SEG_P;
      GLYPH_U:    seg_o = SEG_U;
      GLYPH_DASH: seg_o = SEG_DASH;
      default:    seg_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_msg_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_msg_scroller
//  Description : Buffers a stream of character codes and drives NUM_DIGITS
//                active-low seven-segment digits with a static, left-aligned
//                view or a timed scrolling window over the message.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_msg_scroller #(
  parameter int NUM_DIGITS = 8,
  parameter int DEPTH      = 16,
  parameter int TICK_DIV   = 25_000_000
) (
  input  wire logic          clk_i,
  input  wire logic          resetn_i,
  seg7_msg_scroller_if.slave bus_if
);
  import seg7_pkg::*;

  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);
  // One extra bit so head + position never overflows before the wrap.
  localparam int SUM_W  = LEN_W + 1;

  state_e                      state_q, state_d;
  logic [LEN_W-1:0]            msg_len_q, msg_len_d;
  logic [PTR_W-1:0]            head_q, head_d;
  logic [TICK_W-1:0]           tick_q, tick_d;
  logic [CHAR_W-1:0]           buf_q [DEPTH];
  logic [SEG_W*NUM_DIGITS-1:0] hex_q, hex_d;

  logic             w_wr_ready;
  logic             w_wr_fire;
  logic             w_long;
  logic [PTR_W-1:0] w_last;

  assign w_wr_ready = (msg_len_q < LEN_W'(DEPTH)) & ~bus_if.clear;
  assign w_wr_fire  = bus_if.wr_valid & w_wr_ready;
  // Message longer than the display: the window wraps modulo msg_len.
  assign w_long     = msg_len_q > LEN_W'(NUM_DIGITS);
  assign w_last     = PTR_W'(msg_len_q - LEN_W'(1));

  assign bus_if.wr_ready = w_wr_ready;
  assign bus_if.msg_len  = msg_len_q;
  assign bus_if.hex      = hex_q;

  // Message storage; stale entries are hidden by msg_len so no reset needed.
  always_ff @(posedge clk_i) begin
    if (w_wr_fire) begin
      buf_q[msg_len_q[PTR_W-1:0]] <= bus_if.wr_char;
    end
  end

  // State, length, head and tick registers.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q   <= ST_EMPTY;
      msg_len_q <= '0;
      head_q    <= '0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      msg_len_q <= msg_len_d;
      head_q    <= head_d;
      tick_q    <= tick_d;
    end
  end

  // Next-state: clear wins over writes; head/tick advance only while in SCROLL.
  always_comb begin
    state_d   = state_q;
    msg_len_d = msg_len_q;
    head_d    = head_q;
    tick_d    = tick_q;
    if (bus_if.clear) begin
      state_d   = ST_EMPTY;
      msg_len_d = '0;
      head_d    = '0;
      tick_d    = '0;
    end else begin
      if (w_wr_fire) begin
        msg_len_d = msg_len_q + LEN_W'(1);
      end
      if (state_q == ST_SCROLL) begin
        if (tick_q == TICK_W'(TICK_DIV - 1)) begin
          tick_d = '0;
          if (!bus_if.dir) begin
            head_d = (head_q == w_last) ? '0 : head_q + PTR_W'(1);
          end else begin
            head_d = (head_q == '0) ? w_last : head_q - PTR_W'(1);
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      if (msg_len_d == '0) begin
        state_d = ST_EMPTY;
      end else if ((msg_len_d > LEN_W'(NUM_DIGITS)) && bus_if.scroll_en) begin
        state_d = ST_SCROLL;
      end else begin
        state_d = ST_STATIC;
      end
    end
  end

  // One window position per digit; digit k sits at position NUM_DIGITS-1-k.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int POS = NUM_DIGITS - 1 - k;

    logic [SUM_W-1:0]  w_sum;
    logic [PTR_W-1:0]  w_idx;
    logic              w_show;
    logic [CHAR_W-1:0] w_code;

    assign w_sum  = SUM_W'(head_q) + SUM_W'(POS);
    // head < msg_len and POS < msg_len, so a single subtraction wraps it.
    assign w_idx  = w_long ? PTR_W'((w_sum >= SUM_W'(msg_len_q)) ?
                                    (w_sum - SUM_W'(msg_len_q)) : w_sum)
                           : PTR_W'(POS);
    assign w_show = (state_q != ST_EMPTY) &&
                    (w_long || (LEN_W'(POS) < msg_len_q));
    assign w_code = w_show ? buf_q[w_idx] : GLYPH_BLANK;

    seg7_glyph u_glyph (
      .code_i (w_code),
      .seg_o  (hex_d[SEG_W*k +: SEG_W])
    );
  end

  // Registered segment outputs, blank out of reset.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      hex_q <= '1;
    end else begin
      hex_q <= hex_d;
    end
  end

endmodule
`default_nettype wire
